// File: rtl/fifo_trig_if.sv
// Bundles the FIFO's write, read, status and control signals into one port.
// The FIFO instance connects through the slave modport; its user connects through master.
interface fifo_trig_if #(
    parameter int WIDTH     = 8,
    parameter int TAG_WIDTH = 3,
    parameter int DEPTH     = 16
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic                 flush;
    logic                 wr_en;
    logic [WIDTH-1:0]     wr_data;
    logic [TAG_WIDTH-1:0] wr_tag;
    logic                 rd_en;
    logic [WIDTH-1:0]     rd_data;
    logic [TAG_WIDTH-1:0] rd_tag;
    logic                 rd_valid;
    logic                 empty;
    logic                 full;
    logic [LVL_W-1:0]     level;
    logic [1:0]           trig_sel;
    logic                 trig;
    logic                 overrun;
    logic                 ovr_flag;
    logic                 ovr_clr;
    logic                 err_any;

    modport master (
        output flush, wr_en, wr_data, wr_tag, rd_en, trig_sel, ovr_clr,
        input  rd_data, rd_tag, rd_valid, empty, full, level, trig,
               overrun, ovr_flag, err_any
    );

    modport slave (
        input  flush, wr_en, wr_data, wr_tag, rd_en, trig_sel, ovr_clr,
        output rd_data, rd_tag, rd_valid, empty, full, level, trig,
               overrun, ovr_flag, err_any
    );
endinterface

// File: rtl/fifo_trig.sv
// UART datapath FIFO: data plus status tag per entry, occupancy level, trigger-level
// interrupt, overrun pulse and sticky flag, error-in-FIFO flag, registered or FWFT read.
module fifo_trig #(
    parameter int WIDTH     = 8,
    parameter int TAG_WIDTH = 3,
    parameter int DEPTH     = 16,
    parameter int FWFT      = 0,
    parameter int TRIG0     = 1,
    parameter int TRIG1     = 4,
    parameter int TRIG2     = 8,
    parameter int TRIG3     = 14
) (
    input logic        clk,
    input logic        rst,
    fifo_trig_if.slave bus
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int LVL_W      = ADDR_WIDTH + 1;
    localparam int ENTRY_W    = WIDTH + TAG_WIDTH;

    logic [ENTRY_W-1:0]    mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [LVL_W-1:0]      level_q;
    logic [LVL_W-1:0]      err_cnt;
    logic                  overrun_q;
    logic                  ovr_flag_q;

    logic                  empty_w;
    logic                  full_w;
    logic                  pop;
    logic                  push;
    logic                  ovr_event;
    logic [ENTRY_W-1:0]    head;
    logic                  head_err;
    logic                  wr_err;
    logic [LVL_W-1:0]      threshold;

    assign empty_w   = (level_q == '0);
    assign full_w    = (level_q == LVL_W'(DEPTH));
    assign head      = mem[rd_ptr];
    assign head_err  = |head[TAG_WIDTH-1:0];
    assign wr_err    = |bus.wr_tag;

    // A write into a full FIFO still lands when the head leaves in the same cycle.
    assign pop       = bus.rd_en && !empty_w;
    assign push      = bus.wr_en && (!full_w || pop);
    assign ovr_event = bus.wr_en && full_w && !pop;

    always_ff @(posedge clk) begin
        if (rst && !bus.flush && push) begin
            mem[wr_ptr] <= {bus.wr_data, bus.wr_tag};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || bus.flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            err_cnt    <= '0;
            overrun_q  <= 1'b0;
            ovr_flag_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end

            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase

            // Counts stored entries carrying any error tag bit.
            case ({push && wr_err, pop && head_err})
                2'b10:   err_cnt <= err_cnt + LVL_W'(1);
                2'b01:   err_cnt <= err_cnt - LVL_W'(1);
                default: err_cnt <= err_cnt;
            endcase

            overrun_q <= ovr_event;
            if (ovr_event) begin
                ovr_flag_q <= 1'b1;
            end else if (bus.ovr_clr) begin
                ovr_flag_q <= 1'b0;
            end
        end
    end

    generate
        if (FWFT == 0) begin : g_reg_read
            logic [WIDTH-1:0]     rd_data_q;
            logic [TAG_WIDTH-1:0] rd_tag_q;
            logic                 rd_valid_q;

            always_ff @(posedge clk) begin
                if (!rst || bus.flush) begin
                    rd_data_q  <= '0;
                    rd_tag_q   <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= pop;
                    if (pop) begin
                        rd_data_q <= head[ENTRY_W-1:TAG_WIDTH];
                        rd_tag_q  <= head[TAG_WIDTH-1:0];
                    end
                end
            end

            assign bus.rd_data  = rd_data_q;
            assign bus.rd_tag   = rd_tag_q;
            assign bus.rd_valid = rd_valid_q;
        end else begin : g_fwft_read
            assign bus.rd_data  = head[ENTRY_W-1:TAG_WIDTH];
            assign bus.rd_tag   = head[TAG_WIDTH-1:0];
            assign bus.rd_valid = !empty_w;
        end
    endgenerate

    always_comb begin
        threshold = LVL_W'(TRIG0);
        case (bus.trig_sel)
            2'd0:    threshold = LVL_W'(TRIG0);
            2'd1:    threshold = LVL_W'(TRIG1);
            2'd2:    threshold = LVL_W'(TRIG2);
            default: threshold = LVL_W'(TRIG3);
        endcase
    end

    assign bus.trig     = (level_q >= threshold);
    assign bus.level    = level_q;
    assign bus.empty    = empty_w;
    assign bus.full     = full_w;
    assign bus.overrun  = overrun_q;
    assign bus.ovr_flag = ovr_flag_q;
    assign bus.err_any  = (err_cnt != '0);
endmodule

// File: tb/tb_fifo_trig.sv
// Directed bench for fifo_trig: one registered-read and one FWFT instance checked
// every cycle against a queue-based scoreboard of the expected FIFO contents.
module tb_fifo_trig;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fifo_trig_if #(.WIDTH(8), .TAG_WIDTH(3), .DEPTH(16)) bus0 ();
    fifo_trig_if #(.WIDTH(8), .TAG_WIDTH(3), .DEPTH(16)) bus1 ();

    fifo_trig #(.FWFT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    fifo_trig #(.FWFT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef logic [10:0] entry_t;

    entry_t     q0[$];
    entry_t     q1[$];
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [2:0] exp_tag;
    logic       exp_ovr;
    logic       exp_flag;
    int         thr[4] = '{1, 4, 8, 14};
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    function automatic logic any_err();
        logic e;
        e = 1'b0;
        foreach (q0[i]) begin
            if (q0[i][2:0] != 3'b000) e = 1'b1;
        end
        return e;
    endfunction

    task automatic checkOutput();
        check("rd_valid", bus0.rd_valid, exp_valid);
        check("rd_data", bus0.rd_data, exp_data);
        check("rd_tag", bus0.rd_tag, exp_tag);
        check("level", bus0.level, q0.size());
        check("empty", bus0.empty, q0.size() == 0);
        check("full", bus0.full, q0.size() == 16);
        check("overrun", bus0.overrun, exp_ovr);
        check("ovr_flag", bus0.ovr_flag, exp_flag);
        check("err_any", bus0.err_any, any_err());
        check("trig", bus0.trig, q0.size() >= thr[bus0.trig_sel]);
        check("fwft_rd_valid", bus1.rd_valid, q1.size() != 0);
        check("fwft_empty", bus1.empty, q1.size() == 0);
        check("fwft_level", bus1.level, q1.size());
        if (q1.size() != 0) begin
            check("fwft_rd_data", bus1.rd_data, q1[0][10:3]);
            check("fwft_rd_tag", bus1.rd_tag, q1[0][2:0]);
        end
    endtask

    // Advance both scoreboards with the inputs currently driven, clock, then compare.
    task automatic step();
        int     n;
        logic   p;
        logic   w;
        entry_t e;
        n = q0.size();
        if (!rst || bus0.flush) begin
            q0.delete();
            exp_valid = 1'b0;
            exp_data  = 8'h00;
            exp_tag   = 3'b000;
            exp_ovr   = 1'b0;
            exp_flag  = 1'b0;
        end else begin
            p = bus0.rd_en && (n != 0);
            w = bus0.wr_en && ((n < 16) || p);
            exp_valid = p;
            if (p) begin
                e = q0.pop_front();
                exp_data = e[10:3];
                exp_tag  = e[2:0];
            end
            if (w) q0.push_back({bus0.wr_data, bus0.wr_tag});
            exp_ovr = bus0.wr_en && (n == 16) && !p;
            if (exp_ovr) exp_flag = 1'b1;
            else if (bus0.ovr_clr) exp_flag = 1'b0;
        end
        n = q1.size();
        if (!rst || bus1.flush) begin
            q1.delete();
        end else begin
            p = bus1.rd_en && (n != 0);
            w = bus1.wr_en && ((n < 16) || p);
            if (p) void'(q1.pop_front());
            if (w) q1.push_back({bus1.wr_data, bus1.wr_tag});
        end
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic applyStimulus(input logic wr, input logic [7:0] data,
                                 input logic [2:0] tag, input logic rd);
        bus0.wr_en   = wr;
        bus0.wr_data = data;
        bus0.wr_tag  = tag;
        bus0.rd_en   = rd;
        bus1.wr_en   = 1'b0;
        bus1.rd_en   = 1'b0;
        step();
    endtask

    task automatic fwftStimulus(input logic wr, input logic [7:0] data,
                                input logic [2:0] tag, input logic rd);
        bus0.wr_en   = 1'b0;
        bus0.rd_en   = 1'b0;
        bus1.wr_en   = wr;
        bus1.wr_data = data;
        bus1.wr_tag  = tag;
        bus1.rd_en   = rd;
        step();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0;
        bus0.flush = 1'b0; bus0.wr_en = 1'b0; bus0.wr_data = '0; bus0.wr_tag = '0;
        bus0.rd_en = 1'b0; bus0.trig_sel = 2'd0; bus0.ovr_clr = 1'b0;
        bus1.flush = 1'b0; bus1.wr_en = 1'b0; bus1.wr_data = '0; bus1.wr_tag = '0;
        bus1.rd_en = 1'b0; bus1.trig_sel = 2'd0; bus1.ovr_clr = 1'b0;
        exp_valid = 1'b0; exp_data = '0; exp_tag = '0; exp_ovr = 1'b0; exp_flag = 1'b0;

        applyStimulus(0, 8'h00, 3'b000, 0);
        applyStimulus(0, 8'h00, 3'b000, 0);
        rst = 1'b1;

        $display("[TB] trigger level 14");
        bus0.trig_sel = 2'd3;
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1, 8'(8'h11 + i), 3'b000, 0);
        end
        check("trig_at_14", bus0.trig, 1'b1);

        $display("[TB] fill, overrun, full write+read");
        applyStimulus(1, 8'h1F, 3'b000, 0);
        applyStimulus(1, 8'h20, 3'b000, 0);
        applyStimulus(1, 8'hAA, 3'b000, 0);
        applyStimulus(0, 8'h00, 3'b000, 0);
        bus0.ovr_clr = 1'b1;
        applyStimulus(0, 8'h00, 3'b000, 0);
        bus0.ovr_clr = 1'b0;
        applyStimulus(1, 8'h55, 3'b000, 1);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 8'h00, 3'b000, 1);
        end
        applyStimulus(1, 8'h66, 3'b000, 1);
        applyStimulus(0, 8'h00, 3'b000, 1);
        applyStimulus(0, 8'h00, 3'b000, 0);

        $display("[TB] error tags");
        applyStimulus(1, 8'h41, 3'b000, 0);
        applyStimulus(1, 8'h42, 3'b010, 0);
        applyStimulus(1, 8'h43, 3'b000, 0);
        bus0.trig_sel = 2'd1;
        #1;
        check("trig_sel_comb_1", bus0.trig, q0.size() >= thr[bus0.trig_sel]);
        bus0.trig_sel = 2'd0;
        #1;
        check("trig_sel_comb_0", bus0.trig, q0.size() >= thr[bus0.trig_sel]);
        applyStimulus(0, 8'h00, 3'b000, 1);
        applyStimulus(0, 8'h00, 3'b000, 1);
        applyStimulus(0, 8'h00, 3'b000, 1);

        $display("[TB] flush and mid-stream reset");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 8'(8'h60 + i), 3'(i), 0);
        end
        bus0.flush = 1'b1;
        applyStimulus(1, 8'h99, 3'b111, 0);
        bus0.flush = 1'b0;
        applyStimulus(0, 8'h00, 3'b000, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 8'(8'h70 + i), 3'b100, 0);
        end
        applyStimulus(0, 8'h00, 3'b000, 1);
        rst = 1'b0;
        applyStimulus(1, 8'h77, 3'b001, 1);
        rst = 1'b1;
        applyStimulus(0, 8'h00, 3'b000, 0);

        $display("[TB] FWFT instance");
        fwftStimulus(1, 8'h7E, 3'b000, 0);
        fwftStimulus(0, 8'h00, 3'b000, 1);
        fwftStimulus(1, 8'h03, 3'b001, 0);
        for (int i = 1; i <= 20; i++) begin
            fwftStimulus(1, 8'(i * 7 + 3), 3'(i), 1);
        end
        fwftStimulus(0, 8'h00, 3'b000, 1);
        fwftStimulus(0, 8'h00, 3'b000, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
